// File: rtl/unidade_controle.sv
// rtl/unidade_controle.sv - fetch/decode/execute sequencer for the 8-bit simple processor
//
// Owns the program counter and instruction register, reads instructions from a
// 16x8 synchronous RAM and drives the datapath strobes for registers A/B, the
// ULA and the RAM write port.
//
// Ports:
//   clock       rising-edge system clock
//   reset_n     asynchronous active-low reset
//   start       run request, honoured only in IDLE or HALT
//   mem_rdata   RAM read data (valid the cycle after mem_addr)
//   a_zero      datapath register A == 0
//   mem_addr    RAM address
//   mem_we      RAM write enable (data is register A)
//   alu_opcode  ULA opcode, IR[3:0]
//   alu_enable  ULA enable
//   ld_a, ld_b  register load strobes
//   sel_a       A source: 0 = mem_rdata, 1 = ULA result
//   pc          program counter
//   busy        high outside IDLE and HALT
//   halted      high in HALT
module unidade_controle (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] mem_rdata,
  input  logic       a_zero,
  output logic [3:0] mem_addr,
  output logic       mem_we,
  output logic [3:0] alu_opcode,
  output logic       alu_enable,
  output logic       ld_a,
  output logic       ld_b,
  output logic       sel_a,
  output logic [3:0] pc,
  output logic       busy,
  output logic       halted
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    LOAD   = 3'd4,
    ALUWB  = 3'd5,
    HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_LDB = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JZ  = 4'h6;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t     state, state_nx;
  logic [7:0] ir, ir_nx;
  logic [3:0] pc_nx;
  logic [3:0] opcode;
  logic [3:0] operand;
  logic       is_alu;

  assign opcode     = ir[3:0];
  assign operand    = ir[7:4];
  // 0x8..0xE are ULA ops; 0xF shares bit 3 but is HLT.
  assign is_alu     = opcode[3] && (opcode != OP_HLT);
  assign alu_opcode = opcode;
  assign busy       = (state != IDLE) && (state != HALT);
  assign halted     = (state == HALT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      pc    <= 4'h0;
      ir    <= 8'h00;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      ir    <= ir_nx;
    end
  end

  // Strobes are pure decodes of the state register, so an asynchronous reset
  // drops them immediately and no write-back completes.
  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    ir_nx      = ir;
    mem_addr   = 4'h0;
    mem_we     = 1'b0;
    alu_enable = 1'b0;
    ld_a       = 1'b0;
    ld_b       = 1'b0;
    sel_a      = 1'b0;
    case (state)
      IDLE, HALT: begin
        if (start) begin
          pc_nx    = 4'h0;
          state_nx = FETCH;
        end
      end
      FETCH: begin
        mem_addr = pc;
        state_nx = DECODE;
      end
      DECODE: begin
        ir_nx    = mem_rdata;
        pc_nx    = pc + 4'h1;
        state_nx = EXEC;
      end
      EXEC: begin
        // Operand address goes out for every opcode so LOAD sees the data.
        mem_addr = operand;
        state_nx = FETCH;
        if (is_alu) begin
          alu_enable = 1'b1;
          state_nx   = ALUWB;
        end else begin
          case (opcode)
            OP_LDA, OP_LDB: state_nx = LOAD;
            OP_STA:         mem_we   = 1'b1;
            OP_JMP:         pc_nx    = operand;
            OP_JZ:          if (a_zero) pc_nx = operand;
            OP_HLT:         state_nx = HALT;
            default:        state_nx = FETCH;
          endcase
        end
      end
      LOAD: begin
        ld_a     = (opcode == OP_LDA);
        ld_b     = (opcode == OP_LDB);
        state_nx = FETCH;
      end
      ALUWB: begin
        alu_enable = 1'b1;
        sel_a      = 1'b1;
        ld_a       = 1'b1;
        state_nx   = FETCH;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle.sv
// tb/tb_unidade_controle.sv - directed self-checking bench for unidade_controle
module tb_unidade_controle;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] mem_rdata;
  logic       a_zero;
  logic [3:0] mem_addr;
  logic       mem_we;
  logic [3:0] alu_opcode;
  logic       alu_enable;
  logic       ld_a;
  logic       ld_b;
  logic       sel_a;
  logic [3:0] pc;
  logic       busy;
  logic       halted;

  int checks = 0;
  int errors = 0;

  unidade_controle dut (
    .clock(clock), .reset_n(reset_n), .start(start), .mem_rdata(mem_rdata),
    .a_zero(a_zero), .mem_addr(mem_addr), .mem_we(mem_we),
    .alu_opcode(alu_opcode), .alu_enable(alu_enable), .ld_a(ld_a), .ld_b(ld_b),
    .sel_a(sel_a), .pc(pc), .busy(busy), .halted(halted)
  );

  always #5 clock = ~clock;

  // Datapath model: synchronous RAM, registers A/B, ULA op 0x8 = add.
  logic [7:0] mem [16];
  logic [7:0] prog [16];
  logic       load_prog = 1'b0;
  logic [7:0] reg_a = 8'h00;
  logic [7:0] reg_b = 8'h00;
  logic       az_force = 1'b0;
  logic       az_val = 1'b0;

  assign a_zero = az_force ? az_val : (reg_a == 8'h00);

  always @(posedge clock) begin
    if (load_prog) begin
      for (int i = 0; i < 16; i++) mem[i] <= prog[i];
    end else begin
      mem_rdata <= mem[mem_addr];
      if (mem_we) mem[mem_addr] <= reg_a;
      if (ld_a) reg_a <= sel_a ? (reg_a + reg_b) : mem_rdata;
      if (ld_b) reg_b <= mem_rdata;
    end
  end

  // Per-cycle observations; cycle 1 is the first state after start is taken.
  logic [3:0] o_pc [64];
  logic [3:0] o_addr [64];
  logic [3:0] o_op [64];
  logic       o_we [64], o_lda [64], o_ldb [64], o_alu [64], o_sel [64];
  logic       o_busy [64], o_halt [64];
  int cyc;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    if (cyc < 64) begin
      o_pc[cyc] = pc; o_addr[cyc] = mem_addr; o_op[cyc] = alu_opcode;
      o_we[cyc] = mem_we; o_lda[cyc] = ld_a; o_ldb[cyc] = ld_b;
      o_alu[cyc] = alu_enable; o_sel[cyc] = sel_a;
      o_busy[cyc] = busy; o_halt[cyc] = halted;
    end
  endtask

  task automatic load(input logic [7:0] p [16]);
    for (int i = 0; i < 16; i++) prog[i] = p[i];
    load_prog = 1'b1;
    @(posedge clock);
    #1;
    load_prog = 1'b0;
  endtask

  // Pulses start for one edge and records cycles up to n; a second start pulse
  // is issued at cycle spurious (0 = none) to check it is ignored while busy.
  task automatic run(input int n, input int spurious);
    cyc = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < n) begin
      if (cyc == spurious) start = 1'b1;
      step();
      start = 1'b0;
    end
  endtask

  function automatic int strobe_clash(input int n);
    int c = 0;
    for (int i = 1; i <= n; i++)
      if ((32'(o_we[i]) + 32'(o_lda[i]) + 32'(o_ldb[i])) > 1) c++;
    return c;
  endfunction

  logic [7:0] p [16];
  int cnt;

  initial begin
    // Reset state
    #2;
    chk("rst_pc", {4'h0, pc}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_halted", {7'd0, halted}, 8'h00);
    chk("rst_addr", {4'h0, mem_addr}, 8'h00);
    chk("rst_op", {4'h0, alu_opcode}, 8'h00);
    chk("rst_strobes", {4'h0, mem_we, ld_a, ld_b, alu_enable}, 8'h00);
    for (int i = 0; i < 16; i++) p[i] = 8'h00;
    p[0] = 8'h91; p[1] = 8'hA3; p[2] = 8'h0F; p[9] = 8'h77;
    load(p);
    #3 reset_n = 1'b1;

    // Abort mid-STA: write strobe must drop asynchronously, no write lands.
    run(7, 0);
    chk("sta_we_before_rst", {7'd0, o_we[7]}, 8'h01);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_we", {7'd0, mem_we}, 8'h00);
    chk("rst_async_pc", {4'h0, pc}, 8'h00);
    @(posedge clock);
    #3;
    chk("rst_no_write", mem[10], 8'h00);
    reset_n = 1'b1;
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    chk("idle_busy", {7'd0, busy}, 8'h00);
    chk("idle_pc", {4'h0, pc}, 8'h00);
    chk("idle_halted", {7'd0, halted}, 8'h00);

    // Load/store: LDA 9, STA A, HLT
    p[9] = 8'h5C;
    load(p);
    run(11, 0);
    chk("ls_busy_c1", {7'd0, o_busy[1]}, 8'h01);
    chk("ls_fetch_addr", {4'h0, o_addr[1]}, 8'h00);
    chk("ls_lda_op", {4'h0, o_op[3]}, 8'h01);
    chk("ls_exec_addr", {4'h0, o_addr[3]}, 8'h09);
    chk("ls_lda_c4", {6'd0, o_lda[4], o_sel[4]}, 8'h02);
    cnt = 0;
    for (int i = 1; i <= 11; i++) if (o_lda[i]) cnt++;
    chk("ls_lda_count", 8'(cnt), 8'h01);
    chk("ls_we_c7", {7'd0, o_we[7]}, 8'h01);
    chk("ls_we_addr", {4'h0, o_addr[7]}, 8'h0A);
    chk("ls_we_c6", {7'd0, o_we[6]}, 8'h00);
    chk("ls_halt_c10", {7'd0, o_halt[10]}, 8'h00);
    chk("ls_halted", {7'd0, o_halt[11]}, 8'h01);
    chk("ls_halt_busy", {7'd0, o_busy[11]}, 8'h00);
    chk("ls_halt_pc", {4'h0, o_pc[11]}, 8'h03);
    chk("ls_mem_a", mem[10], 8'h5C);

    // ULA: LDA 9, LDB B, ADD, STA A, HLT  (5 + 3 = 8)
    for (int i = 0; i < 16; i++) p[i] = 8'h00;
    p[0] = 8'h91; p[1] = 8'hB2; p[2] = 8'h08; p[3] = 8'hA3; p[4] = 8'h0F;
    p[9] = 8'h05; p[11] = 8'h03;
    load(p);
    run(19, 0);
    chk("ula_restart_pc", {4'h0, o_pc[1]}, 8'h00);
    chk("ula_restart_halt", {7'd0, o_halt[1]}, 8'h00);
    chk("ula_ldb_c8", {6'd0, o_ldb[8], o_lda[8]}, 8'h02);
    cnt = 0;
    for (int i = 1; i <= 19; i++) if (o_alu[i]) cnt++;
    chk("ula_en_count", 8'(cnt), 8'h02);
    chk("ula_en_c11_12", {6'd0, o_alu[11], o_alu[12]}, 8'h03);
    chk("ula_op", {o_op[11], o_op[12]}, 8'h88);
    chk("ula_exec_strobes", {5'd0, o_lda[11], o_sel[11], o_we[11]}, 8'h00);
    chk("ula_wb", {6'd0, o_lda[12], o_sel[12]}, 8'h03);
    chk("ula_sta_c15", {7'd0, o_we[15]}, 8'h01);
    chk("ula_halted", {7'd0, o_halt[19]}, 8'h01);
    chk("ula_result", mem[10], 8'h08);
    chk("ula_onehot", 8'(strobe_clash(19)), 8'h00);

    // Branching: JZ E taken / not taken
    for (int i = 0; i < 16; i++) p[i] = 8'h00;
    p[0] = 8'hE6; p[1] = 8'h0F; p[14] = 8'h0F;
    load(p);
    az_force = 1'b1;
    az_val = 1'b1;
    run(7, 0);
    chk("jz_t_exec_addr", {4'h0, o_addr[3]}, 8'h0E);
    chk("jz_t_pc", {4'h0, o_pc[4]}, 8'h0E);
    chk("jz_t_fetch_addr", {4'h0, o_addr[4]}, 8'h0E);
    chk("jz_t_halt_pc", {3'd0, o_halt[7], o_pc[7]}, 8'h1F);
    az_val = 1'b0;
    run(7, 0);
    chk("jz_n_pc", {4'h0, o_pc[4]}, 8'h01);
    chk("jz_n_fetch_addr", {4'h0, o_addr[4]}, 8'h01);
    chk("jz_n_halt_pc", {3'd0, o_halt[7], o_pc[7]}, 8'h12);
    az_force = 1'b0;

    // PC wrap over all-NOP memory, with a start pulse while busy
    for (int i = 0; i < 16; i++) p[i] = 8'h00;
    load(p);
    run(49, 20);
    chk("wrap_pc_e", {4'h0, o_pc[43]}, 8'h0E);
    chk("wrap_pc_f", {4'h0, o_pc[46]}, 8'h0F);
    chk("wrap_pc_f_dec", {4'h0, o_pc[47]}, 8'h0F);
    chk("wrap_pc_0_exec", {4'h0, o_pc[48]}, 8'h00);
    chk("wrap_pc_0", {4'h0, o_pc[49]}, 8'h00);
    chk("wrap_fetch_addr", {4'h0, o_addr[46]}, 8'h0F);
    chk("wrap_busy", {6'd0, o_busy[21], o_busy[49]}, 8'h03);
    chk("busy_start_ignored", {4'h0, o_pc[22]}, 8'h07);

    reset_n = 1'b0;
    #10;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
